// File: rtl/freelist_arb.sv
// freelist_arb: round-robin allocation arbiter sharing the freelist pop ports
// among REQ requesters, with flush/drain sequencing.
//
// State table:
//   state    | meaning
//   ST_RUN   | normal allocation; pops granted round-robin from ptr
//   ST_DRAIN | flush recovery; no pops until freelist reports not busy
//
// Ports:
//   clk     - single clock, rising edge
//   reset_  - synchronous active-low reset
//   flush_  - active-low pipeline flush
//   req_    - active-low per-requester allocation request [REQ]
//   gnt     - registered one-cycle grant pulse per requester [REQ]
//   tag     - registered popped entry per requester [REQ*DATA]
//   fl_re_  - active-low pop enables to the freelist [READ]
//   fl_rd   - freelist read data per port [READ*DATA]
//   fl_v    - freelist per-port valid [READ]
//   fl_busy - freelist restoring after flush
//   busy    - arbiter cannot allocate (DRAIN or fl_busy)
module freelist_arb #(
  parameter int REQ  = 8,
  parameter int READ = 4,
  parameter int DATA = 16
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 flush_,
  input  logic [REQ-1:0]       req_,
  output logic [REQ-1:0]       gnt,
  output logic [REQ*DATA-1:0]  tag,
  output logic [READ-1:0]      fl_re_,
  input  logic [READ*DATA-1:0] fl_rd,
  input  logic [READ-1:0]      fl_v,
  input  logic                 fl_busy,
  output logic                 busy
);

  localparam int RP = (REQ > 1) ? $clog2(REQ) : 1;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [REQ-1:0]      gnt_q, gnt_d;
  logic [REQ*DATA-1:0] tag_q, tag_d;
  logic [RP-1:0]       ptr_q, ptr_d;

  logic           alloc_en;
  logic [REQ-1:0] elig;
  logic [REQ-1:0] sel;
  int             avail;
  int             n_sel;
  int             off  [REQ];
  int             rank [REQ];
  int             last_off;
  int             last_idx;
  int             nxt;

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    tag_d    = tag_q;
    ptr_d    = ptr_q;
    fl_re_   = '1;
    elig     = '0;
    sel      = '0;
    avail    = 0;
    n_sel    = 0;
    last_off = -1;
    last_idx = 0;
    nxt      = 0;
    for (int i = 0; i < REQ; i++) begin
      off[i]  = 0;
      rank[i] = 0;
    end

    alloc_en = reset_ && (state_q == ST_RUN) && flush_ && !fl_busy;

    // Only the contiguous run of valid ports from port 0 is usable.
    for (int j = 0; j < READ; j++) begin
      if (fl_v[j] && (avail == j)) avail = j + 1;
    end

    // Scan position of each requester relative to the round-robin pointer.
    for (int i = 0; i < REQ; i++) begin
      off[i] = i - int'(ptr_q);
      if (off[i] < 0) off[i] = off[i] + REQ;
      elig[i] = !req_[i] && !gnt_q[i];
    end

    // rank = number of eligible requesters ahead in scan order = bound port.
    for (int i = 0; i < REQ; i++) begin
      for (int j = 0; j < REQ; j++) begin
        if (elig[j] && (off[j] < off[i])) rank[i] = rank[i] + 1;
      end
      sel[i] = alloc_en && elig[i] && (rank[i] < avail);
    end

    for (int i = 0; i < REQ; i++) begin
      if (sel[i]) begin
        n_sel = n_sel + 1;
        if (off[i] > last_off) begin
          last_off = off[i];
          last_idx = i;
        end
        for (int j = 0; j < READ; j++) begin
          if (rank[i] == j) tag_d[i*DATA +: DATA] = fl_rd[j*DATA +: DATA];
        end
      end
    end

    for (int j = 0; j < READ; j++) begin
      fl_re_[j] = !(alloc_en && (j < n_sel));
    end

    gnt_d = sel;

    if (n_sel > 0) begin
      nxt   = (last_idx + 1 == REQ) ? 0 : last_idx + 1;
      ptr_d = RP'(nxt);
    end

    case (state_q)
      ST_RUN:   if (!flush_) state_d = ST_DRAIN;
      ST_DRAIN: if (flush_ && !fl_busy) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    if (!flush_) ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= ST_RUN;
      gnt_q   <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt  = gnt_q;
  assign tag  = tag_q;
  assign busy = (state_q == ST_DRAIN) | fl_busy;

endmodule

// File: tb/tb_freelist_arb.sv
// tb_freelist_arb: directed self-checking bench for freelist_arb
// (REQ=8, READ=4, DATA=16).
module tb_freelist_arb;

  logic         clk;
  logic         reset_;
  logic         flush_;
  logic [7:0]   req_;
  logic [7:0]   gnt;
  logic [127:0] tag;
  logic [3:0]   fl_re_;
  logic [63:0]  fl_rd;
  logic [3:0]   fl_v;
  logic         fl_busy;
  logic         busy;

  int total = 0;
  int bad   = 0;

  freelist_arb #(.REQ(8), .READ(4), .DATA(16)) dut (
    .clk     (clk),
    .reset_  (reset_),
    .flush_  (flush_),
    .req_    (req_),
    .gnt     (gnt),
    .tag     (tag),
    .fl_re_  (fl_re_),
    .fl_rd   (fl_rd),
    .fl_v    (fl_v),
    .fl_busy (fl_busy),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  int waited;
  int n3;
  logic alloc;
  logic [7:0] r;

  initial begin
    reset_  = 1'b0;
    flush_  = 1'b1;
    req_    = 8'h00;
    fl_v    = 4'hF;
    fl_busy = 1'b0;
    fl_rd   = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};

    // reset
    repeat (5) next();
    chk("rst_gnt", gnt, 0);
    chk("rst_tag", tag, 0);
    chk("rst_re", fl_re_, 4'hF);
    chk("rst_busy0", busy, 0);
    fl_busy = 1'b1;
    #1;
    chk("rst_busy1", busy, 1);
    fl_busy = 1'b0;
    reset_  = 1'b1;

    // all requesting, full freelist
    fl_rd = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    #1;
    chk("all_re0", fl_re_, 4'h0);
    next();
    chk("all_gnt0", gnt, 8'h0F);
    for (int i = 0; i < 4; i++) chk("all_tagA", tag[i*16 +: 16], 16'h00A0 + i);
    chk("all_tag_hi", tag[127:64], 0);
    fl_rd = {16'h00B3, 16'h00B2, 16'h00B1, 16'h00B0};
    #1;
    chk("all_re1", fl_re_, 4'h0);
    next();
    chk("all_gnt1", gnt, 8'hF0);
    for (int i = 0; i < 4; i++) chk("all_tagB", tag[(i+4)*16 +: 16], 16'h00B0 + i);
    chk("all_tag0_hold", tag[15:0], 16'h00A0);
    fl_rd = {16'h00C3, 16'h00C2, 16'h00C1, 16'h00C0};
    next();
    chk("all_gnt2", gnt, 8'h0F);
    chk("all_tagC0", tag[15:0], 16'h00C0);

    // move ptr to 6: only requesters 4,5
    req_ = ~8'h30;
    next();
    chk("ptr6_gnt", gnt, 8'h30);

    // limited availability: requesters 0,6,7 with two ports
    req_  = ~8'hC1;
    fl_v  = 4'b0011;
    fl_rd = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
    #1;
    chk("lim_re", fl_re_, 4'b1100);
    next();
    chk("lim_gnt", gnt, 8'hC0);
    chk("lim_tag6", tag[6*16 +: 16], 16'h00D0);
    chk("lim_tag7", tag[7*16 +: 16], 16'h00D1);
    req_  = ~8'h01;
    fl_rd = {16'h00E3, 16'h00E2, 16'h00E1, 16'h00E0};
    #1;
    chk("lim_re2", fl_re_, 4'b1110);
    next();
    chk("lim_gnt2", gnt, 8'h01);
    chk("lim_tag0", tag[15:0], 16'h00E0);

    // non-contiguous valid: only port 0 usable
    req_ = ~8'h06;
    fl_v = 4'b1101;
    #1;
    chk("nc_re", fl_re_, 4'b1110);
    next();
    chk("nc_gnt", gnt, 8'h02);
    chk("nc_tag1", tag[16 +: 16], 16'h00E0);
    // nothing available: no pop, ptr stays at 2
    req_ = ~8'h05;
    fl_v = 4'h0;
    #1;
    chk("nav_re", fl_re_, 4'hF);
    next();
    chk("nav_gnt", gnt, 8'h00);
    fl_v  = 4'hF;
    fl_rd = {16'h00F3, 16'h00F2, 16'h00F1, 16'h00F0};
    #1;
    chk("nav_re2", fl_re_, 4'b1100);
    next();
    chk("nav_gnt2", gnt, 8'h05);
    chk("nav_tag2", tag[2*16 +: 16], 16'h00F0);
    chk("nav_tag0", tag[15:0], 16'h00F1);

    // flush with requests pending (ptr currently 1)
    req_   = 8'h00;
    flush_ = 1'b0;
    #1;
    chk("fl_re_flush", fl_re_, 4'hF);
    next();
    flush_ = 1'b1;
    chk("fl_gnt_clr", gnt, 8'h00);
    for (int k = 0; k < 3; k++) begin
      fl_busy = 1'b1;
      #1;
      chk("fl_re_drain", fl_re_, 4'hF);
      chk("fl_busy_drain", busy, 1);
      next();
    end
    fl_busy = 1'b0;
    #1;
    chk("fl_re_last", fl_re_, 4'hF);
    chk("fl_busy_last", busy, 1);
    next();
    chk("fl_busy_exit", busy, 0);
    chk("fl_re_exit", fl_re_, 4'h0);
    fl_rd = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    next();
    chk("fl_gnt_exit", gnt, 8'h0F);
    chk("fl_tag0_exit", tag[15:0], 16'h0010);

    // fairness: requester 3 always requesting, single port
    fl_v   = 4'b0001;
    waited = 0;
    n3     = 0;
    for (int c = 0; c < 300; c++) begin
      r    = 8'($urandom);
      r[3] = 1'b0;
      req_ = r;
      #1;
      alloc = ~fl_re_[0];
      next();
      if (alloc) waited++;
      if (gnt[3]) begin
        n3++;
        chk("fair_wait", (waited <= 8), 1);
        waited = 0;
      end
      if (waited > 8) begin
        chk("fair_timeout", waited, 8);
        waited = 0;
      end
    end
    chk("fair_seen", (n3 >= 30), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
